// File: rtl/c17_pipe_param.sv
// Parametrised, bit-level-pipelined ISCAS c17 NAND network with a valid/ready
// handshake, bubble-collapsing stage registers and an in-flight occupancy count.

module c17_pipe_param_stage #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // An empty stage always accepts, so bubbles collapse even under a stall.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

module c17_pipe_param #(
    parameter int         WIDTH     = 1,
    parameter logic [2:0] PIPE_MASK = 3'b011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N1,
    input  logic [WIDTH-1:0] N2,
    input  logic [WIDTH-1:0] N3,
    input  logic [WIDTH-1:0] N6,
    input  logic [WIDTH-1:0] N7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] N22,
    output logic [WIDTH-1:0] N23,
    output logic [1:0]       occ
);
    localparam int L = $countones(PIPE_MASK);

    logic [4*WIDTH-1:0] lvl1_comb, lvl1_data;
    logic [3*WIDTH-1:0] lvl2_comb, lvl2_data;
    logic [2*WIDTH-1:0] lvl3_comb, lvl3_data;
    logic               lvl1_valid, lvl2_valid, lvl3_valid;
    logic               l1_ready, l2_ready, l3_ready;

    logic [WIDTH-1:0] l1_n10, l1_n11, l1_n2, l1_n7;
    logic [WIDTH-1:0] l2_n10, l2_n16, l2_n19;
    logic [WIDTH-1:0] n22_raw, n23_raw;

    // Level buses carry the NAND results plus the raw inputs later levels still need.
    assign lvl1_comb = {~(N1 & N3), ~(N3 & N6), N2, N7};
    assign l1_n10    = lvl1_data[3*WIDTH +: WIDTH];
    assign l1_n11    = lvl1_data[2*WIDTH +: WIDTH];
    assign l1_n2     = lvl1_data[1*WIDTH +: WIDTH];
    assign l1_n7     = lvl1_data[0       +: WIDTH];

    assign lvl2_comb = {l1_n10, ~(l1_n2 & l1_n11), ~(l1_n11 & l1_n7)};
    assign l2_n10    = lvl2_data[2*WIDTH +: WIDTH];
    assign l2_n16    = lvl2_data[1*WIDTH +: WIDTH];
    assign l2_n19    = lvl2_data[0       +: WIDTH];

    assign lvl3_comb = {~(l2_n10 & l2_n16), ~(l2_n16 & l2_n19)};
    assign n22_raw   = lvl3_data[WIDTH +: WIDTH];
    assign n23_raw   = lvl3_data[0     +: WIDTH];

    generate
        if (PIPE_MASK[0]) begin : g_reg1
            c17_pipe_param_stage #(.DW(4*WIDTH)) u_stage (
                .clk(clk), .rst_n(rst_n),
                .in_valid(in_valid), .in_ready(l1_ready), .in_data(lvl1_comb),
                .out_valid(lvl1_valid), .out_ready(l2_ready), .out_data(lvl1_data)
            );
        end else begin : g_wire1
            assign lvl1_valid = in_valid;
            assign lvl1_data  = lvl1_comb;
            assign l1_ready   = l2_ready;
        end

        if (PIPE_MASK[1]) begin : g_reg2
            c17_pipe_param_stage #(.DW(3*WIDTH)) u_stage (
                .clk(clk), .rst_n(rst_n),
                .in_valid(lvl1_valid), .in_ready(l2_ready), .in_data(lvl2_comb),
                .out_valid(lvl2_valid), .out_ready(l3_ready), .out_data(lvl2_data)
            );
        end else begin : g_wire2
            assign lvl2_valid = lvl1_valid;
            assign lvl2_data  = lvl2_comb;
            assign l2_ready   = l3_ready;
        end

        if (PIPE_MASK[2]) begin : g_reg3
            c17_pipe_param_stage #(.DW(2*WIDTH)) u_stage (
                .clk(clk), .rst_n(rst_n),
                .in_valid(lvl2_valid), .in_ready(l3_ready), .in_data(lvl3_comb),
                .out_valid(lvl3_valid), .out_ready(out_ready), .out_data(lvl3_data)
            );
        end else begin : g_wire3
            assign lvl3_valid = lvl2_valid;
            assign lvl3_data  = lvl3_comb;
            assign l3_ready   = out_ready;
        end
    endgenerate

    assign in_ready  = l1_ready;
    assign out_valid = lvl3_valid;

    generate
        if (L == 0) begin : g_comb_only
            assign N22 = n22_raw;
            assign N23 = n23_raw;
            assign occ = 2'd0;
        end else begin : g_piped
            logic       in_fire, out_fire;
            logic [1:0] occ_q, occ_d;

            // Outputs read zero while no result is held, so a reset flushes them too.
            assign N22      = n22_raw & {WIDTH{out_valid}};
            assign N23      = n23_raw & {WIDTH{out_valid}};
            assign in_fire  = in_valid && in_ready;
            assign out_fire = out_valid && out_ready;
            assign occ      = occ_q;

            always_comb begin
                occ_d = occ_q;
                if (in_fire && !out_fire) begin
                    occ_d = occ_q + 2'd1;
                end else if (!in_fire && out_fire) begin
                    occ_d = occ_q - 2'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q <= 2'd0;
                end else begin
                    occ_q <= occ_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_c17_pipe_param.sv
// Directed bench for c17_pipe_param: default mask (L=2), 4-lane L=3 and the
// purely combinational mask, with hand-computed expected outputs.

module tb_c17_pipe_param;
    logic clk;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [0:0] a_n1, a_n2, a_n3, a_n6, a_n7, a_n22, a_n23;
    logic [1:0] a_occ;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_n1, b_n2, b_n3, b_n6, b_n7, b_n22, b_n23;
    logic [1:0] b_occ;

    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [0:0] c_n1, c_n2, c_n3, c_n6, c_n7, c_n22, c_n23;
    logic [1:0] c_occ;

    int tests_run    = 0;
    int tests_failed = 0;

    // Vectors are {N1,N2,N3,N6,N7}; expected N22/N23 worked out by hand.
    logic [4:0] vec   [5] = '{5'b10101, 5'b01010, 5'b10011, 5'b11000, 5'b11111};
    int         exp22 [5] = '{1, 1, 0, 1, 1};
    int         exp23 [5] = '{1, 1, 1, 1, 0};

    int stream_occ [8]  = '{0, 1, 2, 2, 2, 2, 1, 0};
    int bp_occ     [11] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 1, 0};
    int bp_v       [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int bp_ir      [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int bp_idx     [11] = '{0, 0, 2, 2, 2, 2, 2, 2, 3, 4, 0};
    int bb_iv      [7]  = '{1, 0, 1, 0, 0, 0, 0};
    int bb_idx     [7]  = '{0, 0, 4, 0, 0, 0, 0};
    int bb_or      [7]  = '{0, 0, 0, 0, 1, 1, 1};
    int bb_occ     [7]  = '{0, 1, 1, 2, 2, 1, 0};
    int bb_v       [7]  = '{0, 0, 1, 1, 1, 1, 0};
    int bb_ir      [7]  = '{1, 1, 1, 0, 1, 1, 1};
    int bb_oidx    [7]  = '{0, 0, 0, 0, 0, 4, 0};
    int ln_occ     [5]  = '{0, 1, 1, 1, 0};
    int ln_v       [5]  = '{0, 0, 0, 1, 0};

    c17_pipe_param #(.WIDTH(1), .PIPE_MASK(3'b011)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .N1(a_n1), .N2(a_n2), .N3(a_n3), .N6(a_n6), .N7(a_n7),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .N22(a_n22), .N23(a_n23), .occ(a_occ)
    );

    c17_pipe_param #(.WIDTH(4), .PIPE_MASK(3'b111)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .N1(b_n1), .N2(b_n2), .N3(b_n3), .N6(b_n6), .N7(b_n7),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .N22(b_n22), .N23(b_n23), .occ(b_occ)
    );

    c17_pipe_param #(.WIDTH(1), .PIPE_MASK(3'b000)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .N1(c_n1), .N2(c_n2), .N3(c_n3), .N6(c_n6), .N7(c_n7),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .N22(c_n22), .N23(c_n23), .occ(c_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int valid, input int idx, input int ordy);
        a_in_valid  = (valid != 0);
        {a_n1, a_n2, a_n3, a_n6, a_n7} = vec[idx];
        a_out_ready = (ordy != 0);
    endtask

    task automatic runCycle(input string tag, input int iv, input int iidx, input int ordy,
                            input int e_occ, input int e_v, input int e_idx, input int e_ir);
        @(posedge clk);
        #1;
        applyStimulus(iv, iidx, ordy);
        @(negedge clk);
        checkOutput({tag, " occ"}, 32'(a_occ), e_occ);
        checkOutput({tag, " out_valid"}, 32'(a_out_valid), e_v);
        checkOutput({tag, " in_ready"}, 32'(a_in_ready), e_ir);
        if (e_v != 0) begin
            checkOutput({tag, " N22"}, 32'(a_n22), exp22[e_idx]);
            checkOutput({tag, " N23"}, 32'(a_n23), exp23[e_idx]);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        {b_n1, b_n2, b_n3, b_n6, b_n7} = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        {c_n1, c_n2, c_n3, c_n6, c_n7} = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset out_valid", 32'(a_out_valid), 0);
        checkOutput("reset occ", 32'(a_occ), 0);
        checkOutput("reset N22", 32'(a_n22), 0);
        checkOutput("reset N23", 32'(a_n23), 0);
        checkOutput("reset in_ready", 32'(a_in_ready), 1);
        checkOutput("reset lanes out_valid", 32'(b_out_valid), 0);
        checkOutput("reset lanes occ", 32'(b_occ), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 8; c++) begin
            runCycle($sformatf("stream c%0d", c), (c < 5) ? 1 : 0, (c < 5) ? c : 0, 1,
                     stream_occ[c], (c >= 2 && c <= 6) ? 1 : 0, (c >= 2) ? c - 2 : 0, 1);
        end

        for (int c = 0; c < 11; c++) begin
            runCycle($sformatf("backpressure c%0d", c), (c <= 7) ? 1 : 0,
                     (c == 0) ? 2 : ((c == 1) ? 3 : 4), (c >= 7) ? 1 : 0,
                     bp_occ[c], bp_v[c], bp_idx[c], bp_ir[c]);
        end

        for (int c = 0; c < 7; c++) begin
            runCycle($sformatf("bubble c%0d", c), bb_iv[c], bb_idx[c], bb_or[c],
                     bb_occ[c], bb_v[c], bb_oidx[c], bb_ir[c]);
        end

        runCycle("midreset fill c0", 1, 0, 0, 0, 0, 0, 1);
        runCycle("midreset fill c1", 1, 1, 0, 1, 0, 0, 1);
        runCycle("midreset fill c2", 0, 0, 0, 2, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(a_out_valid), 0);
        checkOutput("midreset occ", 32'(a_occ), 0);
        checkOutput("midreset N22", 32'(a_n22), 0);
        checkOutput("midreset N23", 32'(a_n23), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        runCycle("postreset c0", 1, 3, 1, 0, 0, 0, 1);
        runCycle("postreset c1", 0, 0, 1, 1, 0, 0, 1);
        runCycle("postreset c2", 0, 0, 1, 1, 1, 3, 1);
        runCycle("postreset c3", 0, 0, 1, 0, 0, 0, 1);

        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            b_in_valid = (c == 0);
            b_n1 = 4'hD; b_n2 = 4'hA; b_n3 = 4'h1; b_n6 = 4'h6; b_n7 = 4'h5;
            @(negedge clk);
            checkOutput($sformatf("lanes c%0d occ", c), 32'(b_occ), ln_occ[c]);
            checkOutput($sformatf("lanes c%0d out_valid", c), 32'(b_out_valid), ln_v[c]);
            checkOutput($sformatf("lanes c%0d in_ready", c), 32'(b_in_ready), 1);
            if (ln_v[c] != 0) begin
                checkOutput("lanes N22", 32'(b_n22), 32'h0000_000B);
                checkOutput("lanes N23", 32'(b_n23), 32'h0000_000F);
            end
        end

        @(posedge clk);
        #1;
        c_in_valid = 1'b1; c_out_ready = 1'b1;
        {c_n1, c_n2, c_n3, c_n6, c_n7} = vec[4];
        #1;
        checkOutput("comb out_valid", 32'(c_out_valid), 1);
        checkOutput("comb N22", 32'(c_n22), 1);
        checkOutput("comb N23", 32'(c_n23), 0);
        checkOutput("comb in_ready", 32'(c_in_ready), 1);
        checkOutput("comb occ", 32'(c_occ), 0);
        c_out_ready = 1'b0;
        #1;
        checkOutput("comb stall in_ready", 32'(c_in_ready), 0);
        c_out_ready = 1'b1;
        {c_n1, c_n2, c_n3, c_n6, c_n7} = vec[2];
        #1;
        checkOutput("comb vec2 N22", 32'(c_n22), 0);
        checkOutput("comb vec2 N23", 32'(c_n23), 1);
        c_in_valid = 1'b0;
        #1;
        checkOutput("comb idle out_valid", 32'(c_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
